dm_sba: RTL and testbench
=========================

Name: dm_sba

Overview:
- Debug-module System Bus Access engine.
- Implements the sbcs, sbaddress0 and sbdata0 registers (sbcs layout as in sbcs_t) behind the DMI register port.
- Drives a single 32-bit bus master request/acknowledge interface into the core's memory interconnect.
- Lets the debugger read and write memory without halting the hart.

Parameters:
- TIMEOUT_CYCLES, 256, cycles without bus_ack before a timeout error (used only with SBA_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- reg_wr  in  1  DMI register write strobe, one cycle
- reg_rd  in  1  DMI register read strobe, one cycle
- reg_addr  in  7  DM register address: 0x38 sbcs, 0x39 sbaddress0, 0x3C sbdata0
- reg_wdata  in  32  DMI write data
- reg_rdata  out  32  read data, valid the cycle after reg_rd
- bus_req  out  1  bus access request
- bus_we  out  1  1 = write, 0 = read
- bus_addr  out  32  byte address, word aligned
- bus_wdata  out  32  write data
- bus_ack  in  1  access complete, one cycle
- bus_rdata  in  32  read data, valid with bus_ack
- bus_err  in  1  access failed, valid with bus_ack
- sb_busy  out  1  mirror of sbcs.sbbusy

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; sbaddress0=0, sbdata0=0; sberror=0, sbbusyerror=0, sbreadonaddr=0, sbreadondata=0, sbautoincrement=0, sbaccess=2.
- Hardwired sbcs fields on read: sbversion=1, sbasize=32, sbaccess32=1, other sbaccessN=0, reserved bits 0, sbbusy=(state!=IDLE).
- FSM has two states:
  - IDLE: on a start, register bus_addr/bus_we/bus_wdata, assert bus_req next cycle, go to BUSY.
  - BUSY: hold bus_req and all bus outputs stable until bus_ack; on bus_ack, deassert bus_req that same edge and return to IDLE.
  - A new start cannot occur earlier than the cycle after return to IDLE.
- Start is permitted only when sberror==0 and sbbusyerror==0. Before issuing, the start checks are applied in this order:
  - sbaccess!=2 -> sberror=4, no bus access.
  - sbaddress0[1:0]!=0 -> sberror=3, no bus access.
- sbcs write:
  - sbbusyerror and sberror[2:0] are W1C.
  - sbreadonaddr, sbaccess, sbautoincrement, sbreadondata are RW.
  - Permitted while busy, except the RW fields are ignored while busy.
- sbaddress0 write:
  - Busy -> sbbusyerror=1, value dropped.
  - Otherwise store; if sbreadonaddr, start a read.
- sbdata0 write:
  - Busy -> sbbusyerror=1, dropped.
  - Otherwise store and start a write of sbdata0 to sbaddress0.
- sbdata0 read:
  - Busy -> sbbusyerror=1, reg_rdata returns the stale sbdata0.
  - Otherwise return sbdata0; if sbreadondata, start a read after the value is captured.
- Completion without error:
  - A read loads sbdata0 from bus_rdata.
  - If sbautoincrement, sbaddress0 += 4, modulo 2^32 (0xFFFFFFFC wraps to 0x0).
- Completion with bus_err:
  - sberror=7.
  - sbdata0 and sbaddress0 are unchanged.
- Simultaneous events: a register access in the same cycle as bus_ack sees busy=1 and sets sbbusyerror; completion updates still apply.
- A start blocked by sberror/sbbusyerror is silently dropped (register writes still land).
- Unlisted reg_addr: reads return 0, writes are ignored.
- Reset mid-access: bus_req drops immediately; a late bus_ack in IDLE is ignored.

Optional Feature:
- SBA_TIMEOUT_EN defined:
  - A counter runs in BUSY and clears on entry.
  - Reaching TIMEOUT_CYCLES without bus_ack forces IDLE, drops bus_req and sets sberror=1.
  - sbcs reads show sbasize unchanged.
- Not defined: BUSY waits indefinitely; sberror=1 is never produced.

Test Plan:
- Write sbaddress0=0x100, sbdata0=0xDEADBEEF, ack after 3 cycles -> bus_req=1 with bus_we=1, addr 0x100, wdata 0xDEADBEEF held 3 cycles; sbbusy returns to 0; sberror=0.
- sbcs sbreadonaddr=1, sbautoincrement=1; write sbaddress0=0xFFFFFFFC; bus_rdata=0x12345678 -> sbdata0=0x12345678, sbaddress0=0x00000000.
- sbreadondata=1, autoincrement=1, addr 0x200; three sbdata0 reads -> bus reads at 0x200, 0x204, 0x208; each reg_rdata returns the previous word.
- Write sbdata0 while BUSY -> sbbusyerror=1, no second request; next sbdata0 write ignored until sbcs is written with bit22=1 to clear it.
- sbaddress0=0x102 write -> sberror=3, no bus_req; sbaccess=0 then write -> sberror=4; bus_err on ack -> sberror=7, address not incremented.
- (SBA_TIMEOUT_EN, TIMEOUT_CYCLES=16) no ack -> bus_req drops after 16 cycles, sberror=1; rst_n pulse mid-access -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/dm_sba.sv
// rtl/dm_sba.sv - debug-module system bus access engine; define SBA_TIMEOUT_EN to enable the bus timeout
module dm_sba #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [6:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic        sb_busy
);

  localparam logic [6:0] ADDR_SBCS  = 7'h38;
  localparam logic [6:0] ADDR_SBADDR = 7'h39;
  localparam logic [6:0] ADDR_SBDATA = 7'h3C;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] baddr_q, baddr_d;
  logic [31:0] bwdata_q, bwdata_d;
  logic [31:0] sbaddr_q, sbaddr_d;
  logic [31:0] sbdata_q, sbdata_d;
  logic [2:0]  sberror_q, sberror_d;
  logic        busyerr_q, busyerr_d;
  logic        rdonaddr_q, rdonaddr_d;
  logic [2:0]  access_q, access_d;
  logic        autoinc_q, autoinc_d;
  logic        rdondata_q, rdondata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        busy;
  logic        start;
  logic        start_we;
  logic [31:0] sbcs_rd;

`ifdef SBA_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  assign busy = (state_q != IDLE);

  // sbcs read image: version 1, 32-bit address, only 32-bit accesses supported
  assign sbcs_rd = {3'd1, 6'd0, busyerr_q, busy, rdonaddr_q, access_q, autoinc_q,
                    rdondata_q, sberror_q, 7'd32, 5'b00100};

  // register port decode, start checks, bus completion and timeout
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    baddr_d    = baddr_q;
    bwdata_d   = bwdata_q;
    sbaddr_d   = sbaddr_q;
    sbdata_d   = sbdata_q;
    sberror_d  = sberror_q;
    busyerr_d  = busyerr_q;
    rdonaddr_d = rdonaddr_q;
    access_d   = access_q;
    autoinc_d  = autoinc_q;
    rdondata_d = rdondata_q;
    rdata_d    = rdata_q;
    start      = 1'b0;
    start_we   = 1'b0;
`ifdef SBA_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    if (reg_wr) begin
      case (reg_addr)
        ADDR_SBCS: begin
          if (reg_wdata[22]) busyerr_d = 1'b0;
          sberror_d = sberror_q & ~reg_wdata[14:12];
          if (!busy) begin
            rdonaddr_d = reg_wdata[20];
            access_d   = reg_wdata[19:17];
            autoinc_d  = reg_wdata[16];
            rdondata_d = reg_wdata[15];
          end
        end
        ADDR_SBADDR: begin
          if (busy) begin
            busyerr_d = 1'b1;
          end else begin
            sbaddr_d = reg_wdata;
            start    = rdonaddr_q;
          end
        end
        ADDR_SBDATA: begin
          if (busy) begin
            busyerr_d = 1'b1;
          end else begin
            sbdata_d = reg_wdata;
            start    = 1'b1;
            start_we = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (reg_rd) begin
      rdata_d = 32'd0;
      case (reg_addr)
        ADDR_SBCS:   rdata_d = sbcs_rd;
        ADDR_SBADDR: rdata_d = sbaddr_q;
        ADDR_SBDATA: begin
          // the stale value is returned even when busy
          rdata_d = sbdata_q;
          if (busy) busyerr_d = 1'b1;
          else if (rdondata_q) start = 1'b1;
        end
        default: ;
      endcase
    end

    // a start only happens while idle; a sticky error drops it silently
    if (start && (sberror_q == 3'd0) && !busyerr_q) begin
      if (access_q != 3'd2) begin
        sberror_d = 3'd4;
      end else if (sbaddr_d[1:0] != 2'b00) begin
        sberror_d = 3'd3;
      end else begin
        state_d  = BUSY;
        req_d    = 1'b1;
        we_d     = start_we;
        baddr_d  = sbaddr_d;
        bwdata_d = sbdata_d;
`ifdef SBA_TIMEOUT_EN
        cnt_d    = '0;
`endif
      end
    end

    if (busy) begin
      if (bus_ack) begin
        state_d = IDLE;
        req_d   = 1'b0;
        if (bus_err) begin
          sberror_d = 3'd7;
        end else begin
          if (!we_q) sbdata_d = bus_rdata;
          if (autoinc_q) sbaddr_d = sbaddr_q + 32'd4;
        end
      end
`ifdef SBA_TIMEOUT_EN
      else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d   = IDLE;
        req_d     = 1'b0;
        sberror_d = 3'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
`endif
    end
  end

  // state and register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      baddr_q    <= 32'd0;
      bwdata_q   <= 32'd0;
      sbaddr_q   <= 32'd0;
      sbdata_q   <= 32'd0;
      sberror_q  <= 3'd0;
      busyerr_q  <= 1'b0;
      rdonaddr_q <= 1'b0;
      access_q   <= 3'd2;
      autoinc_q  <= 1'b0;
      rdondata_q <= 1'b0;
      rdata_q    <= 32'd0;
`ifdef SBA_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      baddr_q    <= baddr_d;
      bwdata_q   <= bwdata_d;
      sbaddr_q   <= sbaddr_d;
      sbdata_q   <= sbdata_d;
      sberror_q  <= sberror_d;
      busyerr_q  <= busyerr_d;
      rdonaddr_q <= rdonaddr_d;
      access_q   <= access_d;
      autoinc_q  <= autoinc_d;
      rdondata_q <= rdondata_d;
      rdata_q    <= rdata_d;
`ifdef SBA_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign reg_rdata = rdata_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = baddr_q;
  assign bus_wdata = bwdata_q;
  assign sb_busy   = busy;

endmodule

// File: tb/tb_dm_sba.sv
// tb/tb_dm_sba.sv - self-checking bench for dm_sba
module tb_dm_sba;

  localparam logic [6:0] A_CS = 7'h38;
  localparam logic [6:0] A_AD = 7'h39;
  localparam logic [6:0] A_DA = 7'h3C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_wr = 1'b0;
  logic        reg_rd = 1'b0;
  logic [6:0]  reg_addr = 7'd0;
  logic [31:0] reg_wdata = 32'd0;
  logic [31:0] reg_rdata;
  logic        bus_req, bus_we, sb_busy;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;
  logic        bus_err = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  dm_sba #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .sb_busy(sb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_bus;
    logic        exp_we;
    logic [31:0] exp_baddr;
    logic [31:0] exp_bwdata;
    logic [31:0] resp_rdata;
    logic        resp_err;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(input logic w, input logic [6:0] a, input logic [31:0] d,
                              input logic [31:0] er, input logic eb, input logic ewe,
                              input logic [31:0] ea, input logic [31:0] ewd,
                              input logic [31:0] rr, input logic re);
    vec_t v;
    v.is_wr = w; v.addr = a; v.wdata = d; v.exp_rdata = er; v.exp_bus = eb;
    v.exp_we = ewe; v.exp_baddr = ea; v.exp_bwdata = ewd; v.resp_rdata = rr; v.resp_err = re;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // all tasks start and end #1 after a rising edge
  task automatic reg_write(input logic [6:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    @(posedge clk); #1;
    reg_wr = 1'b0;
  endtask

  task automatic reg_read(input logic [6:0] a, output logic [31:0] d);
    reg_rd = 1'b1; reg_addr = a;
    @(posedge clk); #1;
    reg_rd = 1'b0;
    d = reg_rdata;
  endtask

  task automatic no_bus(input string name, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (bus_req) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk(name, {31'd0, seen}, 32'd0);
  endtask

  task automatic serve(input string name, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input int hold, input logic [31:0] rd, input logic err);
    int w;
    w = 0;
    while (!bus_req && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk({name, "_req"}, {31'd0, bus_req}, 32'd1);
    chk({name, "_we"}, {31'd0, bus_we}, {31'd0, we});
    chk({name, "_addr"}, bus_addr, a);
    if (we) chk({name, "_wdata"}, bus_wdata, wd);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, "_hold"}, {bus_req, bus_we, bus_addr[29:0]}, {1'b1, we, a[29:0]});
    end
    bus_ack = 1'b1; bus_rdata = rd; bus_err = err;
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = 32'd0; bus_err = 1'b0;
    chk({name, "_drop"}, {30'd0, bus_req, sb_busy}, 32'd0);
  endtask

  logic [31:0] rd;
  int cnt;

  initial begin
    vecs[0]  = mk(0, A_CS, 0,            32'h20040404, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, A_AD, 32'h100,      0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, A_DA, 32'hDEADBEEF, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0, 0);
    vecs[3]  = mk(0, A_CS, 0,            32'h20040404, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, A_CS, 32'h00150000, 0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, A_AD, 32'hFFFFFFFC, 0, 1, 0, 32'hFFFFFFFC, 0, 32'h12345678, 0);
    vecs[6]  = mk(0, A_AD, 0,            32'h00000000, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, A_DA, 0,            32'h12345678, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, A_CS, 32'h00058000, 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, A_AD, 32'h200,      0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(0, A_DA, 0,            32'h12345678, 1, 0, 32'h200, 0, 32'hA0, 0);
    vecs[11] = mk(0, A_DA, 0,            32'hA0, 1, 0, 32'h204, 0, 32'hA1, 0);
    vecs[12] = mk(0, A_DA, 0,            32'hA1, 1, 0, 32'h208, 0, 32'hA2, 0);
    vecs[13] = mk(0, A_AD, 0,            32'h20C, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk(1, A_CS, 32'h00040000, 0, 0, 0, 0, 0, 0, 0);
    vecs[15] = mk(1, A_AD, 32'h102,      0, 0, 0, 0, 0, 0, 0);
    vecs[16] = mk(1, A_DA, 32'h55,       0, 0, 0, 0, 0, 0, 0);
    vecs[17] = mk(0, A_CS, 0,            32'h20043404, 0, 0, 0, 0, 0, 0);
    vecs[18] = mk(1, A_CS, 32'h00007000, 0, 0, 0, 0, 0, 0, 0);
    vecs[19] = mk(1, A_AD, 32'h300,      0, 0, 0, 0, 0, 0, 0);
    vecs[20] = mk(1, A_DA, 32'h66,       0, 0, 0, 0, 0, 0, 0);
    vecs[21] = mk(0, A_CS, 0,            32'h20004404, 0, 0, 0, 0, 0, 0);
    vecs[22] = mk(1, A_CS, 32'h00057000, 0, 0, 0, 0, 0, 0, 0);
    vecs[23] = mk(1, A_DA, 32'h77,       0, 1, 1, 32'h300, 32'h77, 0, 1);
    vecs[24] = mk(0, A_CS, 0,            32'h20057404, 0, 0, 0, 0, 0, 0);
    vecs[25] = mk(0, A_AD, 0,            32'h300, 0, 0, 0, 0, 0, 0);
    vecs[26] = mk(0, A_DA, 0,            32'h77, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_outputs", {bus_req, bus_we, sb_busy, 29'd0}, 32'd0);
    chk("rst_rdata", reg_rdata, 32'd0);

    for (int i = 0; i < 27; i++) begin
      if (vecs[i].is_wr) begin
        reg_write(vecs[i].addr, vecs[i].wdata);
      end else begin
        reg_read(vecs[i].addr, rd);
        chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      end
      if (vecs[i].exp_bus)
        serve($sformatf("vec%0d_bus", i), vecs[i].exp_we, vecs[i].exp_baddr, vecs[i].exp_bwdata,
              (i == 2) ? 3 : 2, vecs[i].resp_rdata, vecs[i].resp_err);
      else
        no_bus($sformatf("vec%0d_nobus", i), 3);
    end

    // write while busy sets sbbusyerror and blocks later starts until cleared
    reg_write(A_CS, 32'h00047000);
    reg_write(A_AD, 32'h400);
    reg_write(A_DA, 32'h11);
    chk("busy_req", {31'd0, bus_req}, 32'd1);
    reg_write(A_DA, 32'h22);
    chk("busy_hold", {bus_req, sb_busy, 30'd0}, {2'b11, 30'd0});
    chk("busy_wdata", bus_wdata, 32'h11);
    bus_ack = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    no_bus("busy_no_second", 3);
    reg_read(A_CS, rd);
    chk("busyerr_set", rd, 32'h20440404);
    reg_read(A_DA, rd);
    chk("busy_dropped", rd, 32'h11);
    reg_write(A_DA, 32'h33);
    no_bus("busyerr_blocks", 3);
    reg_read(A_DA, rd);
    chk("blocked_lands", rd, 32'h33);
    reg_write(A_CS, 32'h00440000);
    reg_read(A_CS, rd);
    chk("busyerr_clear", rd, 32'h20040404);
    reg_write(A_DA, 32'h44);
    serve("after_clear", 1'b1, 32'h400, 32'h44, 3, 0, 1'b0);

    // asynchronous reset in the middle of an access
    reg_write(A_DA, 32'h99);
    chk("rst_mid_req", {31'd0, bus_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out", {bus_req, bus_we, sb_busy, 29'd0}, 32'd0);
    chk("rst_mid_addr", bus_addr | bus_wdata | reg_rdata, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_err = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_err = 1'b0;
    chk("late_ack_busy", {31'd0, sb_busy}, 32'd0);
    reg_read(A_CS, rd);
    chk("late_ack_sbcs", rd, 32'h20040404);
    reg_read(A_DA, rd);
    chk("rst_sbdata", rd, 32'd0);

    // access with no acknowledge
    reg_write(A_AD, 32'h500);
    reg_write(A_DA, 32'hAB);
    cnt = 0;
    while (bus_req && cnt < 40) begin
      cnt++;
      @(posedge clk); #1;
    end
`ifdef SBA_TIMEOUT_EN
    chk("timeout_cycles", cnt, 32'd16);
    reg_read(A_CS, rd);
    chk("timeout_sberror", rd, 32'h20041404);
`else
    chk("no_timeout_hold", cnt, 32'd40);
    bus_ack = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    reg_read(A_CS, rd);
    chk("no_timeout_sbcs", rd, 32'h20040404);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
